hazard_stall_ctrl: RTL

//  Pipeline hazard/stall controller for the 5-stage core. Tracks destination regs of
//  in-flight insts (EX/MEM/WB scoreboard), compares decode-stage sources, and

---
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Hazard/stall controller for the 5-stage core. There is no forwarding. A
//   small EX/MEM/WB scoreboard of destination registers is compared against
//   the decode-stage sources. The block sequences decode stalls, NOP
//   insertion into ID/EX, branch flushes and whole-pipe freezes while data
//   memory is busy.
//
// Ports
//   clk, rst       core clock; synchronous active-high reset
//   dec_inst       IF/ID instruction (Rs=[10:8], Rt=[7:5])
//   dec_valid      IF/ID holds a real instruction
//   dec_bsrc       source usage: 00 Rs+Rt, 01 Rs only, 1x none
//   dec_regwrite   decode instruction writes dec_rd
//   dec_rd         decode instruction destination register
//   branch_taken   branch/jump resolved taken in EX this cycle
//   mem_busy       data memory not ready (freeze everything)
//   pc_hold        hold PC
//   ifid_hold      hold IF/ID
//   idex_nop_n     low = load NOP into ID/EX
//   flush          squash IF/ID
//   freeze         hold ID/EX, EX/MEM, MEM/WB
//   state          0 RUN, 1 HAZ, 2 FLUSH, 3 MEMW
//   stall_cycles   saturating count of pc_hold cycles
module hazard_stall_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [15:0] NOP_INST     = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dec_inst,
  input  logic        dec_valid,
  input  logic [1:0]  dec_bsrc,
  input  logic        dec_regwrite,
  input  logic [2:0]  dec_rd,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_nop_n,
  output logic        flush,
  output logic        freeze,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, FLUSH = 2'd2, MEMW = 2'd3} state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
  } sb_t;

  // The branch cycle is the first flush cycle, so the counter tracks only the
  // remaining wrong-path slots.
  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  sb_t         sb_ex, sb_mem, sb_wb;
  logic [15:0] stall_q;

  logic [2:0]  rs, rt;
  logic        use_rs, use_rt, hazard;

  function automatic logic hit(input sb_t e, input logic urs, input logic urt,
                               input logic [2:0] s, input logic [2:0] t);
    return e.v & ((urs & (e.rd == s)) | (urt & (e.rd == t)));
  endfunction

  assign rs     = dec_inst[10:8];
  assign rt     = dec_inst[7:5];
  assign use_rs = ~dec_bsrc[1];
  assign use_rt = (dec_bsrc == 2'b00);

  // R0 is treated like any other register; only the canonical NOP is exempt.
  assign hazard = dec_valid & (dec_inst != NOP_INST) &
                  (hit(sb_ex,  use_rs, use_rt, rs, rt) |
                   hit(sb_mem, use_rs, use_rt, rs, rt) |
                   hit(sb_wb,  use_rs, use_rt, rs, rt));

  // Outputs and next state in one priority chain. A nonzero counter only
  // exists in FLUSH, or in MEMW when the freeze interrupted a flush, so the
  // counter alone decides whether to continue flushing.
  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    idex_nop_n = 1'b1;
    flush      = 1'b0;
    freeze     = 1'b0;
    state_d    = RUN;
    cnt_d      = cnt_q;
    if (mem_busy) begin
      freeze    = 1'b1;
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      state_d   = MEMW;
    end else if (branch_taken) begin
      flush      = 1'b1;
      idex_nop_n = 1'b0;
      cnt_d      = CNT_INIT;
      state_d    = (CNT_INIT != 2'd0) ? FLUSH : RUN;
    end else if (cnt_q != 2'd0) begin
      flush      = 1'b1;
      idex_nop_n = 1'b0;
      cnt_d      = cnt_q - 2'd1;
      state_d    = (cnt_q != 2'd1) ? FLUSH : RUN;
    end else if (hazard) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_nop_n = 1'b0;
      state_d    = HAZ;
    end
    if (rst) begin
      pc_hold    = 1'b0;
      ifid_hold  = 1'b0;
      idex_nop_n = 1'b0;
      flush      = 1'b1;
      freeze     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      sb_ex   <= '0;
      sb_mem  <= '0;
      sb_wb   <= '0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!freeze) begin
        sb_wb  <= sb_mem;
        sb_mem <= sb_ex;
        sb_ex  <= {idex_nop_n & dec_regwrite, dec_rd};
      end
      if (pc_hold && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;

endmodule
